fetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end: the PC register, a synchronous-ROM request port and a

---
 rtl/fetch_queue_pkg.sv | 19 +
 rtl/fetch_queue_if.sv | 28 ++
 rtl/fetch_queue_fifo.sv | 41 ++++
 rtl/fetch_queue.sv | 92 +++++++++
 tb/tb_fetch_queue.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM state encoding and entry width helpers.
package fetch_pkg;

    typedef enum logic [1:0] {
        FQ_IDLE = 2'd0,
        FQ_RUN  = 2'd1,
        FQ_HOLD = 2'd2
    } fq_state_e;

    localparam int PC_W_DEF   = 8;
    localparam int INST_W_DEF = 32;
    localparam int ENTRY_W    = PC_W_DEF + INST_W_DEF;

    // A queue entry is {pc+1, inst}, with pc+1 in the upper bits.
    function automatic int entry_width(input int pc_w, input int inst_w);
        return pc_w + inst_w;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the redirect/freeze controls, the instruction-memory port and the IF/ID handshake.
interface fetch_queue_if #(
    parameter int PC_W   = 8,
    parameter int INST_W = 32,
    parameter int CNT_W  = 3
);
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              freeze;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [PC_W-1:0]   out_pcadd;
    logic [CNT_W-1:0]  count;

    modport master (
        input  redirect, redirect_pc, freeze, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_inst, out_pcadd, count
    );

    modport slave (
        output redirect, redirect_pc, freeze, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_inst, out_pcadd, count
    );
endinterface

// File: rtl/fetch_queue_fifo.sv
// Prefetch FIFO: wrap-bit pointers, synchronous clear, simultaneous push and pop.
module fq_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 40,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // The extra wrap bit lets full (count == DEPTH) and empty be told apart.
    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC register, fetch FSM, in-flight tracking and the prefetch FIFO.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           rst_n,
    fetch_queue_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int EW    = entry_width(PC_W, INST_W);

    fq_state_e         state;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   req_pc;
    logic [PC_W-1:0]   req_pc_inc;
    logic              inflight;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic [EW-1:0]     head;
    logic              credit;
    logic              take_redirect;
    logic              issue_redir;
    logic              issue_seq;
    logic              issue;
    logic              push;
    logic              pop;

    // Credit uses registered occupancy only, so out_ready never reaches imem_req.
    assign credit        = (count + CNT_W'(inflight)) < CNT_W'(DEPTH);
    assign take_redirect = bus.redirect && (state != FQ_IDLE);
    assign issue_redir   = take_redirect && !bus.freeze;
    assign issue_seq     = (state == FQ_RUN) && !take_redirect && !bus.freeze && credit;
    assign issue         = !rst_n && (issue_redir || issue_seq);

    assign bus.imem_req  = issue;
    assign bus.imem_addr = take_redirect ? bus.redirect_pc : pc;

    assign req_pc_inc = req_pc + 1'b1;
    assign push       = inflight && !take_redirect;
    assign pop        = !empty && bus.out_ready && !take_redirect;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= FQ_IDLE;
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) req_pc <= bus.imem_addr;
            case (state)
                FQ_IDLE: state <= FQ_RUN;
                FQ_RUN, FQ_HOLD: begin
                    if (take_redirect) begin
                        state <= bus.freeze ? FQ_HOLD : FQ_RUN;
                        pc    <= bus.freeze ? bus.redirect_pc : bus.redirect_pc + 1'b1;
                    end else begin
                        if (issue_seq) pc <= pc + 1'b1;
                        state <= (bus.freeze || !credit) ? FQ_HOLD : FQ_RUN;
                    end
                end
                default: state <= FQ_IDLE;
            endcase
        end
    end

    fq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst_n),
        .clear     (take_redirect),
        .push      (push),
        .push_data ({req_pc_inc, bus.imem_rdata}),
        .pop       (pop),
        .head      (head),
        .empty     (empty),
        .count     (count)
    );

    assign bus.out_valid                 = !empty;
    assign bus.count                     = count;
    assign {bus.out_pcadd, bus.out_inst} = head;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-level reference model plus directed scenarios.
module tb_fetch_queue;

    localparam int              PC_W     = 8;
    localparam int              INST_W   = 32;
    localparam int              DEPTH    = 4;
    localparam int              CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [PC_W-1:0] RESET_PC = '0;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fetch_queue_if #(.PC_W(PC_W), .INST_W(INST_W), .CNT_W(CNT_W)) bus ();

    fetch_queue #(
        .PC_W     (PC_W),
        .INST_W   (INST_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_compared = 0;
    int n_mismatch = 0;

    function automatic logic [INST_W-1:0] rom(input logic [PC_W-1:0] a);
        return {{(INST_W-PC_W){1'b0}}, a};
    endfunction

    // Synchronous ROM with one cycle of latency; idle cycles return a poison word.
    always @(posedge clk) begin
        bus.imem_rdata <= bus.imem_req ? rom(bus.imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    typedef struct packed {
        logic [PC_W-1:0]   pcadd;
        logic [INST_W-1:0] inst;
    } entry_t;

    entry_t          exp_q[$];
    logic [PC_W-1:0] exp_pc    = RESET_PC;
    logic [PC_W-1:0] pend_addr = '0;
    bit              pend      = 1'b0;
    bit              idle      = 1'b1;

    // Reference model: what the queue must hold and which fetches are legal, checked every cycle.
    always @(negedge clk) begin
        check_output("count", 64'(bus.count), 64'(exp_q.size()));
        check_output("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check_output("out_inst", 64'(bus.out_inst), 64'(exp_q[0].inst));
            check_output("out_pcadd", 64'(bus.out_pcadd), 64'(exp_q[0].pcadd));
        end
        if (rst_n || idle || bus.freeze || (!bus.redirect && (exp_q.size() + int'(pend)) >= DEPTH))
            check_output("req_blocked", 64'(bus.imem_req), 64'(0));
        else if (bus.redirect)
            check_output("req_redirect", 64'(bus.imem_req), 64'(1));
        if (bus.imem_req === 1'b1)
            check_output("imem_addr", 64'(bus.imem_addr), 64'(bus.redirect ? bus.redirect_pc : exp_pc));

        if (rst_n) begin
            exp_q.delete();
            exp_pc = RESET_PC;
            pend   = 1'b0;
            idle   = 1'b1;
        end else if (bus.redirect && !idle) begin
            exp_q.delete();
            pend      = !bus.freeze;
            pend_addr = bus.redirect_pc;
            exp_pc    = bus.freeze ? bus.redirect_pc : bus.redirect_pc + 1'b1;
        end else begin
            if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
            if (pend) exp_q.push_back('{pcadd: PC_W'(pend_addr + 1'b1), inst: rom(pend_addr)});
            pend = 1'b0;
            if (bus.imem_req === 1'b1 && !idle) begin
                pend      = 1'b1;
                pend_addr = exp_pc;
                exp_pc    = exp_pc + 1'b1;
            end
            idle = 1'b0;
        end
    end

    task automatic next_cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic r, input logic rd, input logic [PC_W-1:0] rpc,
                                  input logic fz, input logic ry);
        rst_n           = r;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.freeze      = fz;
        bus.out_ready   = ry;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        next_cycle(2);

        // Scenario 1: sequential fetch, two-cycle fetch-to-output latency.
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        next_cycle(1);
        check_output("t1_first_req", 64'(bus.imem_req), 64'(1));
        check_output("t1_first_addr", 64'(bus.imem_addr), 64'(8'h00));
        next_cycle(2);
        check_output("t1_out_valid", 64'(bus.out_valid), 64'(1));
        check_output("t1_out_inst0", 64'(bus.out_inst), 64'(32'h0));
        check_output("t1_out_pcadd1", 64'(bus.out_pcadd), 64'(8'h01));
        next_cycle(1);
        check_output("t1_out_inst1", 64'(bus.out_inst), 64'(32'h1));

        // Scenario 2: consumer stalls, queue saturates, then drains in order.
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        next_cycle(10);
        check_output("t2_count_full", 64'(bus.count), 64'(DEPTH));
        check_output("t2_req_stopped", 64'(bus.imem_req), 64'(0));
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        next_cycle(8);

        // Scenario 3: redirect with three queued entries and a fetch in flight.
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            next_cycle(1);
            if (bus.count == 3) break;
        end
        check_output("t3_count_three", 64'(bus.count), 64'(3));
        apply_stimulus(1'b0, 1'b1, 8'h40, 1'b0, 1'b0);
        #1;
        check_output("t3_redirect_addr", 64'(bus.imem_addr), 64'(8'h40));
        next_cycle(1);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check_output("t3_flushed", 64'(bus.count), 64'(0));
        next_cycle(1);
        check_output("t3_head_inst", 64'(bus.out_inst), 64'(32'h40));
        check_output("t3_head_pcadd", 64'(bus.out_pcadd), 64'(8'h41));

        // Scenario 4: freeze drains the queue and holds the PC.
        next_cycle(4);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        #1;
        check_output("t4_req_frozen", 64'(bus.imem_req), 64'(0));
        next_cycle(3);
        check_output("t4_drained", 64'(bus.count), 64'(0));
        check_output("t4_out_valid", 64'(bus.out_valid), 64'(0));
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        next_cycle(1);
        check_output("t4_resume_req", 64'(bus.imem_req), 64'(1));
        check_output("t4_resume_addr", 64'(bus.imem_addr), 64'(8'h46));
        next_cycle(2);

        // Scenario 5: PC wraps from 0xFF to 0x00.
        apply_stimulus(1'b0, 1'b1, 8'hFE, 1'b0, 1'b1);
        #1;
        check_output("t5_addr_fe", 64'(bus.imem_addr), 64'(8'hFE));
        next_cycle(1);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        #1;
        check_output("t5_addr_ff", 64'(bus.imem_addr), 64'(8'hFF));
        next_cycle(1);
        check_output("t5_addr_wrap", 64'(bus.imem_addr), 64'(8'h00));
        check_output("t5_head_fe", 64'(bus.out_inst), 64'(32'hFE));
        next_cycle(1);
        check_output("t5_head_ff", 64'(bus.out_inst), 64'(32'hFF));
        check_output("t5_pcadd_wrap", 64'(bus.out_pcadd), 64'(8'h00));

        // Scenario 6: reset together with a redirect while the queue is full.
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        next_cycle(8);
        check_output("t6_full", 64'(bus.count), 64'(DEPTH));
        apply_stimulus(1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        #1;
        check_output("t6_req_in_reset", 64'(bus.imem_req), 64'(0));
        next_cycle(1);
        check_output("t6_count_reset", 64'(bus.count), 64'(0));
        check_output("t6_valid_reset", 64'(bus.out_valid), 64'(0));
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        #1;
        check_output("t6_idle_no_req", 64'(bus.imem_req), 64'(0));
        next_cycle(1);
        check_output("t6_first_req", 64'(bus.imem_req), 64'(1));
        check_output("t6_first_addr", 64'(bus.imem_addr), 64'(RESET_PC));
        next_cycle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
